// File: rtl/eth_frame_loop_pkg.sv
// Shared definitions for the frame loopback transmitter: control-word layout,
// FSM state encoding and the unpacked control record.
package eth_frame_loop_pkg;

  localparam int unsigned CTL_W        = 40;
  localparam int unsigned CSUM_VAL_LSB = 17;
  localparam int unsigned CSUM_VAL_W   = 16;
  localparam int unsigned CSUM_POS_LSB = 2;
  localparam int unsigned CSUM_POS_W   = 15;
  localparam int unsigned DROP_BIT     = 1;
  localparam int unsigned FCS_BIT      = 0;

  localparam logic [CSUM_POS_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_CTL,
    ST_FORWARD,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic [CSUM_VAL_W-1:0] csum_val;
    logic [CSUM_POS_W-1:0] csum_pos;
    logic                  drop;
    logic                  fcs_invalid;
  } ctl_t;

  function automatic ctl_t unpack_ctl(input logic [CTL_W-1:0] w);
    ctl_t c;
    c.csum_val    = w[CSUM_VAL_LSB +: CSUM_VAL_W];
    c.csum_pos    = w[CSUM_POS_LSB +: CSUM_POS_W];
    c.drop        = w[DROP_BIT];
    c.fcs_invalid = w[FCS_BIT];
    return c;
  endfunction

endpackage

// File: rtl/eth_frame_loop_tx_if.sv
// Stream bundle for eth_frame_loop_tx: control stream, frame stream and MAC-side
// output stream. slave = the transmitter's view, master = the surrounding logic.
interface eth_frame_loop_tx_if;
  import eth_frame_loop_pkg::*;

  logic [CTL_W-1:0] s_axis_ctl_tdata;
  logic             s_axis_ctl_tvalid;
  logic             s_axis_ctl_tready;

  logic [7:0]       s_axis_frame_tdata;
  logic             s_axis_frame_tlast;
  logic             s_axis_frame_tvalid;
  logic             s_axis_frame_tready;

  logic [7:0]       m_axis_tdata;
  logic             m_axis_tuser;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  modport slave (
    input  s_axis_ctl_tdata, s_axis_ctl_tvalid,
    output s_axis_ctl_tready,
    input  s_axis_frame_tdata, s_axis_frame_tlast, s_axis_frame_tvalid,
    output s_axis_frame_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_ctl_tdata, s_axis_ctl_tvalid,
    input  s_axis_ctl_tready,
    output s_axis_frame_tdata, s_axis_frame_tlast, s_axis_frame_tvalid,
    input  s_axis_frame_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/eth_frame_loop_tx.sv
// Frame loopback transmitter: per-frame control word selects forward (with optional
// 16-bit checksum overwrite and FCS-corrupt flag) or discard; zero-latency data path.
module eth_frame_loop_tx
  import eth_frame_loop_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  eth_frame_loop_tx_if.slave  bus,
  output logic [31:0]         tx_frames,
  output logic [31:0]         drop_frames
);

  state_t                state_q, state_d;
  ctl_t                  ctl_q, ctl_d;
  logic [CSUM_POS_W-1:0] idx_q, idx_d;
  logic [31:0]           tx_frames_q, tx_frames_d;
  logic [31:0]           drop_frames_q, drop_frames_d;

  logic                  ctl_tready;
  logic                  frame_tready;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tuser;
  logic [7:0]            m_tdata;
  logic [CSUM_POS_W-1:0] idx_inc;
  logic [CSUM_POS_W:0]   pos_ext;
  logic [CSUM_POS_W:0]   idx_ext;
  logic                  csum_en;
  logic                  unused_bits;

  // Upper control bits and the latched drop flag carry no downstream meaning.
  always_comb unused_bits = ^{bus.s_axis_ctl_tdata[CTL_W-1:CSUM_VAL_LSB+CSUM_VAL_W], ctl_q.drop};

  always_comb begin
    idx_inc = (idx_q == IDX_MAX) ? idx_q : idx_q + 1'b1;
    pos_ext = {1'b0, ctl_q.csum_pos};
    idx_ext = {1'b0, idx_q};
    csum_en = (ctl_q.csum_pos != '0);
  end

  always_comb begin
    state_d       = state_q;
    ctl_d         = ctl_q;
    idx_d         = idx_q;
    tx_frames_d   = tx_frames_q;
    drop_frames_d = drop_frames_q;
    ctl_tready    = 1'b0;
    frame_tready  = 1'b0;
    m_tvalid      = 1'b0;
    m_tlast       = 1'b0;
    m_tuser       = 1'b0;
    m_tdata       = '0;

    unique case (state_q)
      ST_WAIT_CTL: begin
        ctl_tready = 1'b1;
        if (bus.s_axis_ctl_tvalid) begin
          ctl_d   = unpack_ctl(bus.s_axis_ctl_tdata);
          idx_d   = '0;
          state_d = ctl_d.drop ? ST_DISCARD : ST_FORWARD;
        end
      end

      ST_FORWARD: begin
        m_tvalid     = bus.s_axis_frame_tvalid;
        frame_tready = bus.m_axis_tready;
        m_tlast      = bus.s_axis_frame_tlast;
        m_tuser      = bus.s_axis_frame_tlast & ctl_q.fcs_invalid;
        // Positions past the frame end never match an emitted index, so short frames truncate naturally.
        if (csum_en && idx_ext == pos_ext) begin
          m_tdata = ctl_q.csum_val[15:8];
        end else if (csum_en && idx_ext == pos_ext + 1'b1) begin
          m_tdata = ctl_q.csum_val[7:0];
        end else begin
          m_tdata = bus.s_axis_frame_tdata;
        end
        if (bus.s_axis_frame_tvalid && bus.m_axis_tready) begin
          idx_d = idx_inc;
          if (bus.s_axis_frame_tlast) begin
            tx_frames_d = tx_frames_q + 32'd1;
            state_d     = ST_WAIT_CTL;
          end
        end
      end

      ST_DISCARD: begin
        frame_tready = 1'b1;
        if (bus.s_axis_frame_tvalid) begin
          idx_d = idx_inc;
          if (bus.s_axis_frame_tlast) begin
            drop_frames_d = drop_frames_q + 32'd1;
            state_d       = ST_WAIT_CTL;
          end
        end
      end

      default: state_d = ST_WAIT_CTL;
    endcase

    // Outputs are forced quiet for the whole reset cycle, not just after the edge.
    if (rst) begin
      ctl_tready   = 1'b0;
      frame_tready = 1'b0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      m_tuser      = 1'b0;
      m_tdata      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_CTL;
      ctl_q         <= '0;
      idx_q         <= '0;
      tx_frames_q   <= '0;
      drop_frames_q <= '0;
    end else begin
      state_q       <= state_d;
      ctl_q         <= ctl_d;
      idx_q         <= idx_d;
      tx_frames_q   <= tx_frames_d;
      drop_frames_q <= drop_frames_d;
    end
  end

  assign bus.s_axis_ctl_tready   = ctl_tready;
  assign bus.s_axis_frame_tready = frame_tready;
  assign bus.m_axis_tvalid       = m_tvalid;
  assign bus.m_axis_tlast        = m_tlast;
  assign bus.m_axis_tuser        = m_tuser;
  assign bus.m_axis_tdata        = m_tdata;
  assign tx_frames               = rst ? '0 : tx_frames_q;
  assign drop_frames             = rst ? '0 : drop_frames_q;

endmodule
